// File: rtl/tp_capture_if.sv
// Probe, trigger-configuration and readout signals of the tp_capture block.
// The master side drives probes, trigger setup and read strobes; the slave side is the capture block.
interface tp_capture_if #(
    parameter int NCH = 4,
    parameter int W   = 16
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH*W-1:0] PROBE;
    logic             PROBE_VLD;
    logic             ARM;
    logic [SW-1:0]    TRIG_SEL;
    logic [W-1:0]     TRIG_MASK;
    logic [W-1:0]     TRIG_VAL;
    logic [1:0]       TRIG_MODE;
    logic             FORCE_TRIG;
    logic             RD_EN;
    logic [NCH*W-1:0] RD_DATA;
    logic             RD_VLD;
    logic [15:0]      RD_TS;
    logic [2:0]       STATE;
    logic             DONE;

    modport master (
        output PROBE, PROBE_VLD, ARM, TRIG_SEL, TRIG_MASK, TRIG_VAL, TRIG_MODE, FORCE_TRIG, RD_EN,
        input  RD_DATA, RD_VLD, RD_TS, STATE, DONE
    );
    modport slave (
        input  PROBE, PROBE_VLD, ARM, TRIG_SEL, TRIG_MASK, TRIG_VAL, TRIG_MODE, FORCE_TRIG, RD_EN,
        output RD_DATA, RD_VLD, RD_TS, STATE, DONE
    );
endinterface

// File: rtl/tp_capture.sv
// Test-point capture: circular probe buffer with masked trigger, PRE pre-trigger samples, oldest-first readout.
// Optional TP_TIMESTAMP_EN stores a saturating 16-bit cycle stamp with each sample and returns it on RD_TS.
module tp_capture #(
    parameter int NCH   = 4,
    parameter int W     = 16,
    parameter int DEPTH = 32,
    parameter int PRE   = 8
) (
    input  logic           SYS_CLK,
    input  logic           RESET,
    tp_capture_if.slave    bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = NCH * W;
    localparam int POSTN = DEPTH - PRE;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_wp, r_rp;
    logic [CW-1:0]   r_cnt;
    logic            r_prev_match, r_force;
    logic [PW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_rd_data;
    logic            r_rd_vld;

    logic [W-1:0]    w_ch;
    logic            w_match, w_hit, w_force, w_wr, w_rd, w_trig;

    always_comb begin
        w_ch    = bus.PROBE[int'(bus.TRIG_SEL)*W +: W];
        w_match = ((w_ch ^ bus.TRIG_VAL) & bus.TRIG_MASK) == '0;
        w_force = r_force | bus.FORCE_TRIG;
        // ARM wins over a same-cycle sample or read, so both are gated here
        w_wr    = bus.PROBE_VLD & ~bus.ARM &
                  ((r_state == S_PRE) | (r_state == S_WAIT) | (r_state == S_POST));
        w_rd    = bus.RD_EN & ~bus.ARM & (r_state == S_DONE);
        case (bus.TRIG_MODE)
            2'b00:   w_hit = w_match;
            2'b01:   w_hit = ~w_match;
            2'b10:   w_hit = w_match & ~r_prev_match;
            default: w_hit = 1'b1;
        endcase
        w_trig = w_wr & (r_state == S_WAIT) & (w_hit | w_force);
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.ARM) begin
            w_state_nxt = S_PRE;
        end else begin
            case (r_state)
                S_PRE:  if (w_wr && r_cnt == CW'(PRE - 1)) w_state_nxt = S_WAIT;
                S_WAIT: if (w_trig) w_state_nxt = (POSTN == 1) ? S_DONE : S_POST;
                S_POST: if (w_wr && r_cnt == CW'(POSTN - 1)) w_state_nxt = S_DONE;
                S_DONE: if (w_rd && r_cnt == CW'(DEPTH - 1)) w_state_nxt = S_IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // r_cnt counts pre-trigger fill, then post-trigger samples, then reads
    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_cnt        <= '0;
            r_prev_match <= 1'b0;
            r_force      <= 1'b0;
            r_rd_data    <= '0;
            r_rd_vld     <= 1'b0;
        end else begin
            r_rd_vld <= 1'b0;
            if (bus.ARM) begin
                r_wp         <= '0;
                r_cnt        <= '0;
                r_prev_match <= 1'b0;
                r_force      <= 1'b0;
            end else begin
                if (w_wr) r_wp <= r_wp + 1'b1;
                if (w_trig)              r_force <= 1'b0;
                else if (bus.FORCE_TRIG) r_force <= 1'b1;
                if (w_wr && r_state == S_WAIT) r_prev_match <= w_match;
                case (r_state)
                    S_PRE:  if (w_wr) r_cnt <= (r_cnt == CW'(PRE - 1)) ? '0 : r_cnt + 1'b1;
                    S_WAIT: if (w_trig) begin
                        r_rp  <= r_wp - AW'(PRE);
                        r_cnt <= (POSTN == 1) ? '0 : CW'(1);
                    end
                    S_POST: if (w_wr) r_cnt <= (r_cnt == CW'(POSTN - 1)) ? '0 : r_cnt + 1'b1;
                    S_DONE: if (w_rd) begin
                        r_rd_data <= r_mem[r_rp];
                        r_rd_vld  <= 1'b1;
                        r_rp      <= r_rp + 1'b1;
                        r_cnt     <= r_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (w_wr) r_mem[r_wp] <= bus.PROBE;
    end

`ifdef TP_TIMESTAMP_EN
    logic [15:0] r_ts, r_rd_ts;
    logic [15:0] r_ts_mem [DEPTH];

    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            r_ts    <= '0;
            r_rd_ts <= '0;
        end else begin
            if (bus.ARM)               r_ts <= '0;
            else if (r_ts != 16'hFFFF) r_ts <= r_ts + 1'b1;
            if (w_rd) r_rd_ts <= r_ts_mem[r_rp];
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (w_wr) r_ts_mem[r_wp] <= r_ts;
    end

    assign bus.RD_TS = r_rd_ts;
`else
    assign bus.RD_TS = 16'h0000;
`endif

    assign bus.RD_DATA = r_rd_data;
    assign bus.RD_VLD  = r_rd_vld;
    assign bus.STATE   = r_state;
    assign bus.DONE    = (r_state == S_DONE);
endmodule

// File: tb/tb_tp_capture.sv
// Bench for tp_capture: trigger-mode vector table, directed capture/readout sequences and
// randomized traffic, all checked against a queue-based capture model.
module tb_tp_capture;
    localparam int NCH = 4, W = 16, DEPTH = 32, PRE = 8;
    localparam int PW = NCH * W;

    logic SYS_CLK = 1'b0;
    logic RESET   = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    tp_capture_if #(.NCH(NCH), .W(W)) bus ();
    tp_capture #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .PRE(PRE)) dut (
        .SYS_CLK (SYS_CLK),
        .RESET   (RESET),
        .bus     (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: sample history since ARM plus trigger index
    logic [PW-1:0] hq[$];
    logic [15:0]   tq[$];
    int            m_state = 0, m_tidx = 0, m_rdn = 0;
    bit            m_prev = 0, m_force = 0, e_vld = 0;
    logic [15:0]   m_ts = 0, e_ts = 0;
    logic [PW-1:0] e_data = '0;

    logic [PW-1:0] rbuf [DEPTH+1];
    logic [15:0]   tbuf [DEPTH+1];

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  sel;
        logic [15:0] mask, val, d0, d1;
        logic [2:0]  s0, s1;
    } vec_t;
    vec_t vt [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] pk(input logic [15:0] c0, input logic [15:0] c1);
        return {16'h3333, 16'h2222, c1, c0};
    endfunction

    function automatic logic [PW-1:0] vs(input int sel, input logic [15:0] d);
        logic [PW-1:0] p;
        for (int k = 0; k < NCH; k++) p[k*W +: W] = (k == sel) ? d : ~d;
        return p;
    endfunction

    task automatic mdl(input bit arm, input bit vld, input bit frc, input bit rd, input logic [PW-1:0] pr);
        logic [W-1:0] ch;
        logic [15:0]  tsn;
        bit           mt, tg;
        tsn   = m_ts;
        m_ts  = arm ? 16'h0 : ((m_ts == 16'hFFFF) ? m_ts : m_ts + 16'h1);
        e_vld = 0;
`ifndef TP_TIMESTAMP_EN
        tsn = 16'h0;
`endif
        if (arm) begin
            m_state = 1; hq.delete(); tq.delete(); m_prev = 0; m_force = 0;
        end else begin
            if (frc) m_force = 1;
            ch = pr[int'(bus.TRIG_SEL)*W +: W];
            mt = ((ch ^ bus.TRIG_VAL) & bus.TRIG_MASK) == '0;
            case (m_state)
                1: if (vld) begin
                    hq.push_back(pr); tq.push_back(tsn);
                    if (hq.size() == PRE) m_state = 2;
                end
                2: if (vld) begin
                    hq.push_back(pr); tq.push_back(tsn);
                    case (bus.TRIG_MODE)
                        2'b00:   tg = mt;
                        2'b01:   tg = !mt;
                        2'b10:   tg = mt && !m_prev;
                        default: tg = 1;
                    endcase
                    tg = tg || m_force;
                    m_prev = mt;
                    if (tg) begin
                        m_tidx = hq.size() - 1; m_force = 0; m_rdn = 0;
                        m_state = (DEPTH - PRE == 1) ? 4 : 3;
                    end
                end
                3: if (vld) begin
                    hq.push_back(pr); tq.push_back(tsn);
                    if (hq.size() - m_tidx == DEPTH - PRE) m_state = 4;
                end
                4: if (rd) begin
                    e_vld  = 1;
                    e_data = hq[m_tidx - PRE + m_rdn];
                    e_ts   = tq[m_tidx - PRE + m_rdn];
                    m_rdn++;
                    if (m_rdn == DEPTH) m_state = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input bit arm, input bit vld, input bit frc, input bit rd, input logic [PW-1:0] pr);
        bus.ARM = arm; bus.PROBE_VLD = vld; bus.FORCE_TRIG = frc; bus.RD_EN = rd; bus.PROBE = pr;
        @(posedge SYS_CLK);
        mdl(arm, vld, frc, rd, pr);
        #1;
        chk("state", bus.STATE, m_state);
        chk("done", bus.DONE, m_state == 4);
        chk("rd_vld", bus.RD_VLD, e_vld);
        if (e_vld) begin
            chk("rd_data", bus.RD_DATA, e_data);
            chk("rd_ts", bus.RD_TS, e_ts);
        end
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b1;
        bus.ARM = 0; bus.PROBE_VLD = 0; bus.FORCE_TRIG = 0; bus.RD_EN = 0; bus.PROBE = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge SYS_CLK);
            m_state = 0; m_ts = 0; m_prev = 0; m_force = 0; e_vld = 0;
            hq.delete(); tq.delete();
            #1;
            chk("rst_state", bus.STATE, 3'd0);
            chk("rst_done", bus.DONE, 1'b0);
            chk("rst_rd_vld", bus.RD_VLD, 1'b0);
            chk("rst_rd_data", bus.RD_DATA, '0);
            chk("rst_rd_ts", bus.RD_TS, 16'h0);
        end
        RESET = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] mode, input logic [1:0] sel, input logic [15:0] mask, input logic [15:0] val);
        bus.TRIG_MODE = mode; bus.TRIG_SEL = sel; bus.TRIG_MASK = mask; bus.TRIG_VAL = val;
    endtask

    task automatic readout(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 0, 1, '0);
            rbuf[i] = bus.RD_DATA;
            tbuf[i] = bus.RD_TS;
        end
    endtask

    initial begin
        vt[0] = '{2'd0, 2'd0, 16'hFFFF, 16'h0014, 16'h0013, 16'h0014, 3'd2, 3'd3};
        vt[1] = '{2'd0, 2'd2, 16'h00F0, 16'h0A30, 16'h1234, 16'h0000, 3'd3, 3'd3};
        vt[2] = '{2'd1, 2'd1, 16'hFFFF, 16'h0005, 16'h0005, 16'h0006, 3'd2, 3'd3};
        vt[3] = '{2'd2, 2'd1, 16'hFFFF, 16'h0005, 16'h0000, 16'h0005, 3'd2, 3'd3};
        vt[4] = '{2'd2, 2'd3, 16'h000F, 16'h0005, 16'hFFF5, 16'h0000, 3'd3, 3'd3};
        vt[5] = '{2'd3, 2'd0, 16'hFFFF, 16'h0000, 16'h1111, 16'h2222, 3'd3, 3'd3};
        vt[6] = '{2'd0, 2'd1, 16'h0000, 16'hFFFF, 16'h1234, 16'h4321, 3'd3, 3'd3};
        vt[7] = '{2'd1, 2'd2, 16'h0000, 16'h0000, 16'h1234, 16'h4321, 3'd2, 3'd2};
        vt[8] = '{2'd0, 2'd3, 16'hFFFF, 16'h00AA, 16'h0055, 16'h00AA, 3'd2, 3'd3};

        cfg(2'd3, 2'd0, 16'hFFFF, 16'h0000);
        do_reset(2);

        // reset mid-POST, then ARM alone
        cyc(1, 0, 0, 0, '0);
        for (int i = 0; i <= PRE; i++) cyc(0, 1, 0, 0, pk(16'(i), 16'h0));
        chk("t1_post", bus.STATE, 3'd3);
        do_reset(2);
        cyc(1, 0, 0, 0, '0);
        chk("t1_arm", bus.STATE, 3'd1);

        // equal trigger on ch0 == 0x14, then 33 back-to-back reads
        cfg(2'd0, 2'd0, 16'hFFFF, 16'h0014);
        cyc(1, 0, 0, 0, '0);
        for (int n = 0; n <= 'h2B; n++) begin
            cyc(0, 1, 0, 0, pk(16'(n), ~16'(n)));
            chk("t2_state", bus.STATE, (n == 'h2B) ? 3'd4 : (n < 7) ? 3'd1 : (n < 'h14) ? 3'd2 : 3'd3);
        end
        for (int i = 0; i <= DEPTH; i++) begin
            cyc(0, 0, 0, 1, '0);
            if (i < DEPTH) begin
                chk("t2_vld", bus.RD_VLD, 1'b1);
                chk("t2_data", bus.RD_DATA, pk(16'('h0C + i), ~16'('h0C + i)));
            end else begin
                chk("t5_extra_vld", bus.RD_VLD, 1'b0);
            end
            if (i == 8) chk("t2_read8", bus.RD_DATA[15:0], 16'h0014);
            if (i == DEPTH - 1) chk("t5_idle", bus.STATE, 3'd0);
        end

        // trigger-mode table
        foreach (vt[v]) begin
            cfg(vt[v].mode, vt[v].sel, vt[v].mask, vt[v].val);
            cyc(1, 0, 0, 0, '0);
            for (int i = 0; i < PRE; i++) cyc(0, 1, 0, 0, '0);
            cyc(0, 1, 0, 0, vs(int'(vt[v].sel), vt[v].d0));
            chk($sformatf("vec%0d_s0", v), bus.STATE, vt[v].s0);
            cyc(0, 1, 0, 0, vs(int'(vt[v].sel), vt[v].d1));
            chk($sformatf("vec%0d_s1", v), bus.STATE, vt[v].s1);
        end

        // rising match: pre-trigger matches must not count, ch1 = 0,5,5,0,5
        cfg(2'd2, 2'd1, 16'hFFFF, 16'h0005);
        cyc(1, 0, 0, 0, '0);
        for (int i = 0; i < PRE; i++) cyc(0, 1, 0, 0, pk(16'(i), 16'h5));
        begin
            logic [15:0] seq [5];
            logic [2:0]  exs [5];
            seq = '{16'h0, 16'h5, 16'h5, 16'h0, 16'h5};
            exs = '{3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
            for (int i = 0; i < 5; i++) begin
                cyc(0, 1, 0, 0, pk(16'(PRE + i), seq[i]));
                chk("t3_state", bus.STATE, exs[i]);
            end
        end
        for (int i = PRE + 5; i <= PRE + 1 + DEPTH - PRE - 1; i++) cyc(0, 1, 0, 0, pk(16'(i), 16'h7));
        chk("t3_done", bus.STATE, 3'd4);
        readout(DEPTH);
        chk("t3_read8", rbuf[8][15:0], 16'(PRE + 1));
        chk("t3_read7", rbuf[7][15:0], 16'(PRE));

        // forced trigger with non-matching data
        cfg(2'd0, 2'd0, 16'hFFFF, 16'hDEAD);
        cyc(1, 0, 0, 0, '0);
        for (int i = 0; i < 11; i++) cyc(0, 1, 0, 0, pk(16'(i), 16'h0));
        cyc(0, 0, 1, 0, '0);
        chk("t4_wait", bus.STATE, 3'd2);
        cyc(0, 1, 0, 0, pk(16'd11, 16'h0));
        chk("t4_forced", bus.STATE, 3'd3);
        for (int i = 12; i <= 11 + DEPTH - PRE - 1; i++) cyc(0, 1, 0, 0, pk(16'(i), 16'h0));
        chk("t4_done", bus.STATE, 3'd4);
        readout(DEPTH);
        chk("t4_read8", rbuf[8][15:0], 16'd11);

        // ARM during readout after 3 reads, with same-cycle RD_EN
        cfg(2'd3, 2'd0, 16'hFFFF, 16'h0000);
        cyc(1, 0, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 0, pk(16'(i), 16'h0));
        chk("t4b_done", bus.STATE, 3'd4);
        readout(3);
        cyc(1, 0, 0, 1, '0);
        chk("t4b_arm_state", bus.STATE, 3'd1);
        chk("t4b_arm_vld", bus.RD_VLD, 1'b0);
        cyc(0, 0, 0, 1, '0);
        chk("t4b_rd_ignored", bus.RD_VLD, 1'b0);

        // one sample every 4 cycles: timestamps step by 4 (or stay 0)
        cyc(1, 0, 0, 0, '0);
        for (int s = 0; s < DEPTH; s++) begin
            cyc(0, 1, 0, 0, pk(16'(s), 16'h0));
            for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, '0);
        end
        readout(DEPTH);
        for (int i = 1; i < DEPTH; i++) begin
`ifdef TP_TIMESTAMP_EN
            chk("t6_ts_step", tbuf[i] - tbuf[i-1], 16'd4);
`else
            chk("t6_ts_zero", tbuf[i], 16'h0);
`endif
        end

        // randomized traffic against the model
        for (int it = 0; it < 6; it++) begin
            cfg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 1) != 0) ? 16'h0003 : 16'hFFFF, 16'($urandom_range(0, 3)));
            cyc(1, 0, 0, 0, '0);
            for (int c = 0; c < 400; c++) begin
                logic [PW-1:0] p;
                bit a;
                for (int k = 0; k < NCH; k++) p[k*W +: W] = 16'($urandom_range(0, 3));
                a = (m_state == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 499) == 0);
                cyc(a, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 1) != 0, p);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
